// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite to APB4 bridge for single transfers.
// One AHB data phase maps onto one APB SETUP/ACCESS pair. HREADYOUT is held
// low until the APB side completes or until the PREADY timeout aborts the access.
module ahbl_apb_bridge #(
    parameter int ADDR_W  = 28,
    parameter int TIMEOUT = 255
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic [31:0]       HRDATA,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [3:0]        PSTRB,
    output logic [31:0]       PWDATA,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    output logic              TIMEOUT_ERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam logic [15:0] TO_LIM   = 16'(TIMEOUT);
    localparam logic        TO_EN    = (TIMEOUT != 0);
    localparam logic [31:0] ABORT_RD = 32'hBADD_BEEF;

    state_e              state_q;
    logic [15:0]         cnt_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic                pwrite_q;
    logic [3:0]          pstrb_q;
    logic [31:0]         hrdata_q;
    logic                psel_q;
    logic                penable_q;
    logic                hreadyout_q;
    logic                terr_q;

    logic                start;
    logic [3:0]          pstrb_d;
    logic                unused_in;

    // Only the page offset and the NONSEQ/SEQ bit are used.
    assign unused_in = ^{HADDR, HTRANS[0]};

    assign start = HSEL & HTRANS[1] & HREADY;

    // Byte-lane strobes for the captured transfer; reads carry no strobes.
    always_comb begin
        pstrb_d = 4'b0000;
        if (HWRITE) begin
            case (HSIZE)
                3'd0:    pstrb_d = 4'b0001 << HADDR[1:0];
                3'd1:    pstrb_d = 4'b0011 << {HADDR[1], 1'b0};
                default: pstrb_d = 4'b1111;
            endcase
        end
    end

    // Bridge FSM; every APB/AHB control output is registered here.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pstrb_q     <= 4'b0000;
            hrdata_q    <= 32'd0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
            terr_q      <= 1'b0;
        end else begin
            terr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        paddr_q     <= HADDR[ADDR_W-1:0];
                        pwrite_q    <= HWRITE;
                        pstrb_q     <= pstrb_d;
                        psel_q      <= 1'b1;
                        hreadyout_q <= 1'b0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= 16'd0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        if (!pwrite_q) hrdata_q <= PRDATA;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        hreadyout_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (TO_EN && cnt_q == TO_LIM) begin
                        // Hung peripheral: release the AHB bus with a marker value.
                        hrdata_q    <= ABORT_RD;
                        terr_q      <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        hreadyout_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (cnt_q != 16'hFFFF) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    hreadyout_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign HREADYOUT   = hreadyout_q;
    assign HRDATA      = hrdata_q;
    assign PADDR       = paddr_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PSTRB       = pstrb_q;
    assign PWDATA      = HWDATA;
    assign TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Scoreboard bench for ahbl_apb_bridge. Two bridges share the AHB/APB buses:
// dut 0 has TIMEOUT = 4, dut 1 has TIMEOUT = 0 (timeout disabled).
module tb_ahbl_apb_bridge;

    typedef struct packed {
        logic [27:0] paddr;
        logic        pwrite;
        logic [3:0]  pstrb;
        logic [31:0] pwdata;
        logic [31:0] rdata;
        logic        terr;
        logic [15:0] waits;
        logic        b2b;
        logic        abort;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [1:0]  hsel = 2'b00;
    logic [31:0] HADDR = 32'd0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'd0;
    logic [31:0] HWDATA = 32'd0;
    logic        HREADY;
    logic [31:0] PRDATA = 32'd0;
    logic        PREADY = 1'b0;

    logic [1:0]        hro;
    logic [1:0][31:0]  hrdata;
    logic [1:0][27:0]  paddr;
    logic [1:0]        psel, penable, pwrite, terr;
    logic [1:0][3:0]   pstrb;
    logic [1:0][31:0]  pwdata;

    int   n_cmp = 0;
    int   n_err = 0;
    int   wait_n = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];

    bit   infl [2];
    bit   post [2];
    int   wcnt [2];
    int   last_done [2];

    assign HREADY = hro[0] & hro[1];

    always #5 HCLK = ~HCLK;

    ahbl_apb_bridge #(.ADDR_W(28), .TIMEOUT(4)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(hro[0]), .HRDATA(hrdata[0]),
        .PADDR(paddr[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PSTRB(pstrb[0]), .PWDATA(pwdata[0]),
        .PRDATA(PRDATA), .PREADY(PREADY), .TIMEOUT_ERR(terr[0])
    );

    ahbl_apb_bridge #(.ADDR_W(28), .TIMEOUT(0)) u_dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(hro[1]), .HRDATA(hrdata[1]),
        .PADDR(paddr[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PSTRB(pstrb[1]), .PWDATA(pwdata[1]),
        .PRDATA(PRDATA), .PREADY(PREADY), .TIMEOUT_ERR(terr[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic qpush(input int d, input exp_t e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    function automatic int qsz(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qdrop(input int d);
        if (d == 0) q0.delete(0); else q1.delete(0);
    endtask

    // APB slave model: PREADY low for wait_n ACCESS cycles, then high.
    always @(negedge HCLK) begin
        if ((psel[0] && penable[0]) || (psel[1] && penable[1])) begin
            if (wait_n > 0) begin
                PREADY = 1'b0;
                wait_n = wait_n - 1;
            end else begin
                PREADY = 1'b1;
            end
        end else begin
            PREADY = 1'b0;
        end
    end

    // Monitor step for one bridge: checks APB fields at SETUP, latency and
    // response at completion, and that TIMEOUT_ERR drops after one cycle.
    task automatic mon_step(input int d);
        exp_t e;
        if (!HRESETn) begin
            infl[d] = 1'b0;
            post[d] = 1'b0;
            if (qsz(d) > 0) begin
                e = qfront(d);
                if (e.abort) qdrop(d);
            end
            return;
        end
        if (post[d]) begin
            chk($sformatf("d%0d terr_one_cycle", d), 32'(terr[d]), 32'd0);
            post[d] = 1'b0;
        end
        if (psel[d] && !penable[d]) begin
            if (qsz(d) == 0) begin
                chk($sformatf("d%0d unexpected_setup", d), 32'd1, 32'd0);
            end else begin
                e = qfront(d);
                chk($sformatf("d%0d paddr", d), 32'(paddr[d]), 32'(e.paddr));
                chk($sformatf("d%0d pwrite", d), 32'(pwrite[d]), 32'(e.pwrite));
                chk($sformatf("d%0d pstrb", d), 32'(pstrb[d]), 32'(e.pstrb));
                chk($sformatf("d%0d pwdata", d), pwdata[d], e.pwdata);
                if (e.b2b)
                    chk($sformatf("d%0d b2b_setup_cycle", d), 32'(cyc), 32'(last_done[d] + 1));
                infl[d] = 1'b1;
                wcnt[d] = 0;
            end
        end
        if (infl[d]) begin
            if (!hro[d]) begin
                wcnt[d]++;
            end else begin
                e = qfront(d);
                chk($sformatf("d%0d wait_states", d), 32'(wcnt[d]), 32'(e.waits));
                chk($sformatf("d%0d hrdata", d), hrdata[d], e.rdata);
                chk($sformatf("d%0d timeout_err", d), 32'(terr[d]), 32'(e.terr));
                qdrop(d);
                infl[d] = 1'b0;
                post[d] = 1'b1;
                last_done[d] = cyc;
            end
        end
    endtask

    always @(negedge HCLK) begin
        mon_step(0);
        mon_step(1);
        cyc++;
    end

    // Wait (bounded) for the global HREADY; called at posedge + 1.
    task automatic wait_hready(input string nm);
        int g;
        g = 0;
        while (!HREADY && g < 2000) begin
            @(posedge HCLK); #1;
            g++;
        end
        if (!HREADY) chk(nm, 32'd0, 32'd1);
    endtask

    // One AHB transfer on bridge d with its hand-computed expected response.
    task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                        input logic [2:0] sz, input logic [31:0] wd, input logic [31:0] rd,
                        input int wn, input logic [3:0] x_strb, input logic [31:0] x_rdata,
                        input logic x_terr, input int x_waits, input logic b2b);
        exp_t e;
        wait_hready("hready_before_start");
        e.paddr  = addr[27:0];
        e.pwrite = wr;
        e.pstrb  = x_strb;
        e.pwdata = wd;
        e.rdata  = x_rdata;
        e.terr   = x_terr;
        e.waits  = 16'(x_waits);
        e.b2b    = b2b;
        e.abort  = 1'b0;
        qpush(d, e);
        hsel      = (d == 0) ? 2'b01 : 2'b10;
        HTRANS    = 2'b10;
        HADDR     = addr;
        HWRITE    = wr;
        HSIZE     = sz;
        PRDATA    = rd;
        wait_n    = wn;
        @(posedge HCLK); #1;
        hsel   = 2'b00;
        HTRANS = 2'b00;
        HWDATA = wd;
        wait_hready("hready_completion");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        exp_t e;
        repeat (3) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        @(negedge HCLK);
        chk("rst hreadyout", 32'(hro[0]), 32'd1);
        chk("rst hrdata", hrdata[0], 32'd0);
        chk("rst psel", 32'(psel[0]), 32'd0);
        chk("rst penable", 32'(penable[0]), 32'd0);
        chk("rst pwrite", 32'(pwrite[0]), 32'd0);
        chk("rst pstrb", 32'(pstrb[0]), 32'd0);
        chk("rst paddr", 32'(paddr[0]), 32'd0);
        chk("rst terr", 32'(terr[0]), 32'd0);
        @(posedge HCLK); #1;

        //   d  addr          wr sz    wdata          prdata        wn  strb     rdata          te  w  b2b
        xfer(0, 32'h2000_0010, 1, 3'd2, 32'hCAFE_F00D, 32'h0,         0, 4'b1111, 32'h0,         0, 2, 0);
        xfer(0, 32'h2000_0020, 0, 3'd2, 32'h0,         32'h1234_5678, 3, 4'b0000, 32'h1234_5678, 0, 5, 0);
        xfer(0, 32'h3000_0003, 1, 3'd0, 32'hAB00_0000, 32'h0,         0, 4'b1000, 32'h1234_5678, 0, 2, 0);
        xfer(0, 32'h0ABC_0006, 1, 3'd1, 32'h5566_0000, 32'h0,         0, 4'b1100, 32'h1234_5678, 0, 2, 0);
        xfer(0, 32'h0000_0041, 1, 3'd0, 32'h0000_7700, 32'h0,         0, 4'b0010, 32'h1234_5678, 0, 2, 0);
        xfer(0, 32'h0000_0045, 1, 3'd3, 32'h1111_2222, 32'h0,         0, 4'b1111, 32'h1234_5678, 0, 2, 0);
        xfer(0, 32'h0000_0100, 1, 3'd2, 32'hA1A2_A3A4, 32'h0,         0, 4'b1111, 32'h1234_5678, 0, 2, 0);
        xfer(0, 32'h0000_0104, 0, 3'd2, 32'h0,         32'hDEAD_0104, 0, 4'b0000, 32'hDEAD_0104, 0, 2, 1);
        // timeout: PREADY stuck low, ACCESS lasts 5 cycles
        xfer(0, 32'h0000_0200, 0, 3'd2, 32'h0,         32'h7777_7777, 1000, 4'b0000, 32'hBADD_BEEF, 1, 6, 0);
        xfer(0, 32'h0000_0204, 0, 3'd2, 32'h0,         32'h0F0F_0F0F, 0, 4'b0000, 32'h0F0F_0F0F, 0, 2, 1);
        // timeout disabled: 300 PREADY-low cycles are waited out
        xfer(1, 32'h0000_0300, 0, 3'd2, 32'h0,         32'h55AA_55AA, 300, 4'b0000, 32'h55AA_55AA, 0, 302, 0);
        wait_n = 0;

        // reset in the middle of ACCESS
        wait_hready("hready_before_abort");
        e = '0;
        e.paddr = 28'h000_0400;
        e.abort = 1'b1;
        qpush(0, e);
        hsel = 2'b01; HTRANS = 2'b10; HADDR = 32'h0000_0400; HWRITE = 1'b0; HSIZE = 3'd2;
        HWDATA = 32'h0; wait_n = 1000;
        @(posedge HCLK); #1;
        hsel = 2'b00; HTRANS = 2'b00;
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        chk("pre_rst in_access", 32'(psel[0] & penable[0]), 32'd1);
        #1 HRESETn = 1'b0;
        #1;
        chk("async_rst psel", 32'(psel[0]), 32'd0);
        chk("async_rst penable", 32'(penable[0]), 32'd0);
        chk("async_rst hreadyout", 32'(hro[0]), 32'd1);
        chk("async_rst hrdata", hrdata[0], 32'd0);
        chk("async_rst pstrb_paddr", {pstrb[0], paddr[0]}, 32'd0);
        @(negedge HCLK); #2;
        wait_n = 0;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // IDLE and BUSY transfer types must never start an APB access
        hsel = 2'b11;
        for (int i = 0; i < 6; i++) begin
            HTRANS = (i < 3) ? 2'b00 : 2'b01;
            @(negedge HCLK);
            chk($sformatf("idle_busy psel[%0d]", i), 32'(psel), 32'd0);
            @(posedge HCLK); #1;
        end
        hsel = 2'b00; HTRANS = 2'b00;

        xfer(0, 32'h2000_0040, 1, 3'd2, 32'h0BAD_CAFE, 32'h0,         1, 4'b1111, 32'h0,         0, 3, 0);
        xfer(0, 32'h2000_0044, 0, 3'd2, 32'h0,         32'hA5A5_0001, 0, 4'b0000, 32'hA5A5_0001, 0, 2, 1);

        repeat (4) @(posedge HCLK);
        #1;
        chk("sb_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahbl_apb_bridge.md
# ahbl_apb_bridge

AHB-Lite slave that converts single AHB-Lite transfers into APB4 transfers. It sits directly downstream of one slave port of the AHB-Lite address splitter and drives an APB peripheral subsystem. It adds wait states through HREADYOUT until the APB access completes. A programmable PREADY timeout keeps a hung peripheral from stalling the bus.

## Interface
- ADDR_W, 28: PADDR width; PADDR = HADDR[ADDR_W-1:0], which is the offset inside the 256MB page.
- TIMEOUT, 255: maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout. Legal range 0..65535.
- HCLK  in  1  single clock for the AHB and APB sides.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from the splitter.
- HADDR  in  32  AHB address.
- HTRANS  in  2  transfer type; only bit 1 (NONSEQ/SEQ) starts a transfer.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word; other values are treated as word.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  global bus ready (muxed return from the splitter).
- HREADYOUT  out  1  this slave's ready.
- HRDATA  out  32  registered read data.
- PADDR  out  ADDR_W  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PSTRB  out  4  APB4 byte strobes.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- TIMEOUT_ERR  out  1  one-cycle pulse when an access is aborted by timeout.

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS.
- Start condition: HSEL & HTRANS[1] & HREADY.
  - In IDLE, a start captures PADDR <= HADDR[ADDR_W-1:0], PWRITE <= HWRITE and the PSTRB source (HSIZE, HADDR[1:0]), then moves to SETUP.
  - IDLE and BUSY transfers, and starts with HREADY low, are ignored.
- PSTRB on writes:
  - Byte: 4'b0001 << HADDR[1:0].
  - Halfword: 4'b0011 << {HADDR[1],1'b0}.
  - Word: 4'b1111.
  - Reads: PSTRB = 0.
- SETUP: PSEL = 1, PENABLE = 0, HREADYOUT = 0. The FSM moves to ACCESS unconditionally and clears the timeout counter.
- ACCESS: PSEL = 1, PENABLE = 1, HREADYOUT = 0.
  - PREADY = 1: latch HRDATA <= PRDATA (reads only; writes leave HRDATA unchanged) and go to IDLE.
  - PREADY = 0: increment the counter. When the counter reaches TIMEOUT (TIMEOUT ≠ 0), go to IDLE, load HRDATA <= 32'hBADDBEEF and pulse TIMEOUT_ERR.
- IDLE drives HREADYOUT = 1, PSEL = 0 and PENABLE = 0.
- The cycle after completion is IDLE with HREADYOUT = 1, which ends the AHB data phase. A new start in that same cycle is accepted (back-to-back transfers).
- PWDATA = HWDATA (combinational). It is valid through SETUP and ACCESS because the master must hold HWDATA while HREADYOUT = 0.
- PADDR, PWRITE and PSTRB hold their last values in IDLE. They change only on a start.
- The counter is 16 bits and saturates; it never wraps.
- Reset values: HREADYOUT = 1, HRDATA = 0, PSEL = 0, PENABLE = 0, PWRITE = 0, PSTRB = 0, PADDR = 0, TIMEOUT_ERR = 0, state = IDLE, counter = 0.
- Reset asserted mid-transfer returns everything to the reset values immediately (async). The APB access is abandoned.

## Timing
- T0: address phase, start sampled.
- T1: SETUP.
- T2: ACCESS.
- PREADY = 1 at T2 gives T3 = IDLE with HREADYOUT = 1 and HRDATA valid. A zero-wait APB slave therefore costs 2 AHB wait states.
- Each PREADY-low cycle in ACCESS adds one wait state.
- Timeout: with PREADY held low, ACCESS lasts TIMEOUT + 1 cycles, then IDLE.
- TIMEOUT_ERR is high for exactly the first IDLE cycle after an abort.
- HREADYOUT is never low in IDLE and never high in SETUP or ACCESS.
- HSEL/HTRANS activity during SETUP or ACCESS is ignored. Those cycles have HREADY low, so no start can occur.

## Test plan
- **Word write:** HADDR = 0x2000_0010, HWRITE = 1, HSIZE = 2, HWDATA = 0xCAFE_F00D, PREADY = 1.
  - Expect PSEL at T1; PENABLE at T2 with PADDR = 0x000_0010 and PSTRB = 4'hF; HREADYOUT low at T1–T2 and high at T3.
- **Read with wait states:** PREADY low for 3 ACCESS cycles, PRDATA = 0x1234_5678.
  - Expect HREADYOUT low for 5 cycles, then HRDATA = 0x1234_5678 with HREADYOUT = 1.
- **Byte/halfword strobes:**
  - Byte write at HADDR[1:0] = 3 gives PSTRB = 4'b1000.
  - Halfword write at HADDR[1:0] = 2 gives PSTRB = 4'b1100.
  - Read gives PSTRB = 0.
- **Back-to-back:** a write followed immediately by a read, second start in the completion cycle.
  - Expect the second SETUP one cycle after completion, and no IDLE gap beyond that cycle.
- **Timeout:** TIMEOUT = 4, PREADY stuck low.
  - Expect ACCESS for 5 cycles, then HRDATA = 0xBADDBEEF, a one-cycle TIMEOUT_ERR pulse and HREADYOUT = 1.
  - With TIMEOUT = 0 and PREADY low for 300 cycles, expect no abort.
- **Reset mid-ACCESS:** HRESETn low during ACCESS.
  - Expect PSEL = PENABLE = 0, HREADYOUT = 1 and HRDATA = 0 asynchronously.
  - IDLE/BUSY HTRANS after reset produces no PSEL.
